rom_loader: RTL and testbench

- Byte-stream writer that fills a synchronous on-chip memory (ROM/RAM image) at boot or on host download.
- Accepts 8-bit bytes over a valid/ready handshake from the host/ioctl download path.
- Assembles bytes into DW-bit words and issues one-cycle write strobes with an incrementing address.
- Sits between the download interface and the write port of the memory whose read side the CPU/video logic uses.

---
 rtl/rom_loader.sv | 138 +++++++++++++
 tb/tb_rom_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: turns a valid/ready byte stream into word writes for an on-chip memory.
// Bytes are packed little-endian into DW-bit words (DW = 8 or 16). Each completed word
// produces a single-cycle write strobe at an address that counts up from 0. When the
// memory is full, further bytes are still accepted but thrown away, and the sticky
// overflow flag is set. A trailing odd byte in DW=16 mode is written out as a
// zero-padded word when the load finishes.
module rom_loader #(
  parameter int unsigned KB = 16,
  parameter int unsigned DW = 8,
  localparam int unsigned AW = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          finish,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          we,
  output logic [AW-1:0] a,
  output logic [DW-1:0] d,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = (AW + 1)'(KB * 1024);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_t;

  state_t        state;
  // Words already committed to a strobe; this is the address of the next word.
  logic [AW:0]   wptr;
  // DW=16 only: set while a low byte is waiting for its partner.
  logic          phase;
  logic [7:0]    lo;

  logic          accept;
  logic          full;
  logic          take;
  logic          drop;
  logic          load_end;
  logic          word_done;
  logic          flush;
  logic          phase_next;
  logic [7:0]    lo_next;
  logic [DW-1:0] word;

  // Byte handling for this cycle: assemble, complete, drop, or flush a leftover byte
  always_comb begin
    accept     = s_valid && s_ready && !start;
    full       = (wptr == DEPTH);
    take       = accept && !full;
    drop       = accept && full;
    load_end   = finish && (state == StLoad) && !start;
    word_done  = 1'b0;
    flush      = 1'b0;
    phase_next = phase;
    lo_next    = lo;
    word       = '0;
    if (take) begin
      if (DW == 8) begin
        word_done = 1'b1;
        word      = DW'(s_data);
      end else if (!phase) begin
        lo_next    = s_data;
        phase_next = 1'b1;
      end else begin
        word_done  = 1'b1;
        word       = DW'({s_data, lo});
        phase_next = 1'b0;
      end
    end
    // The byte arriving together with finish is counted first; only a byte still
    // left waiting after that gets flushed.
    if (load_end && !word_done && phase_next && !full) begin
      flush = 1'b1;
      word  = DW'({8'h00, lo_next});
    end
  end

  // Control FSM with registered status and write-port outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      we       <= 1'b0;
      a        <= '0;
      d        <= '0;
      count    <= '0;
      wptr     <= '0;
      phase    <= 1'b0;
      lo       <= '0;
    end else begin
      we    <= 1'b0;
      count <= count + {{AW{1'b0}}, we};
      if (start) begin
        // A restart abandons everything, including a strobe about to be counted.
        state    <= StLoad;
        s_ready  <= 1'b1;
        busy     <= 1'b1;
        done     <= 1'b0;
        overflow <= 1'b0;
        count    <= '0;
        wptr     <= '0;
        phase    <= 1'b0;
      end else if (state == StLoad) begin
        phase <= phase_next;
        lo    <= lo_next;
        if (drop) begin
          overflow <= 1'b1;
        end
        if (word_done || flush) begin
          we   <= 1'b1;
          a    <= wptr[AW-1:0];
          d    <= word;
          wptr <= wptr + (AW + 1)'(1);
        end
        if (load_end) begin
          state   <= StDone;
          s_ready <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          phase   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: drives identical byte streams into a DW=8 and a DW=16 loader (both
// KB=1). A byte-image model predicts, for each instance, every cycle's outputs.
// Directed sequences additionally compare the logged writes against literal values.
module tb_rom_loader;

  localparam int DEPTH = 1024;

  logic        clock;
  logic        reset;
  logic        start;
  logic        finish;
  logic [7:0]  s_data;
  logic        s_valid;

  logic        rdy8, we8, busy8, done8, ovf8;
  logic [9:0]  a8;
  logic [7:0]  d8;
  logic [10:0] cnt8;
  logic        rdy16, we16, busy16, done16, ovf16;
  logic [9:0]  a16;
  logic [15:0] d16;
  logic [10:0] cnt16;

  int checks = 0;
  int errors = 0;

  rom_loader #(.KB(1), .DW(8)) u_dw8 (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy8), .we(we8), .a(a8), .d(d8),
    .busy(busy8), .done(done8), .overflow(ovf8), .count(cnt8)
  );

  rom_loader #(.KB(1), .DW(16)) u_dw16 (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy16), .we(we16), .a(a16), .d(d16),
    .busy(busy16), .done(done16), .overflow(ovf16), .count(cnt16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state per instance: index 0 is DW=8 (1 byte/word), index 1 is DW=16.
  logic [7:0]  mbuf [2][2*DEPTH];
  int          m_load [2];
  int          m_done [2];
  int          m_nb   [2];
  int          m_ovf  [2];
  int          m_cnt  [2];
  int          m_we   [2];
  int          m_a    [2];
  logic [15:0] m_d    [2];

  logic [31:0] wr8[$];
  logic [31:0] wr16[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  // Memory-image view: words are whole groups of stored bytes; a stray odd byte is
  // what gets flushed at finish.
  task automatic model_step();
    int bpw;
    int k;
    for (int u = 0; u < 2; u++) begin
      bpw = u + 1;
      if (!reset) begin
        m_load[u] = 0; m_done[u] = 0; m_nb[u] = 0; m_ovf[u] = 0;
        m_cnt[u] = 0; m_we[u] = 0; m_a[u] = 0; m_d[u] = '0;
      end else begin
        m_cnt[u] += m_we[u];
        m_we[u] = 0;
        if (start) begin
          m_load[u] = 1; m_done[u] = 0; m_nb[u] = 0; m_ovf[u] = 0; m_cnt[u] = 0;
        end else if (m_load[u] != 0) begin
          if (s_valid) begin
            if (m_nb[u] >= DEPTH * bpw) begin
              m_ovf[u] = 1;
            end else begin
              mbuf[u][m_nb[u]] = s_data;
              m_nb[u]++;
              if (m_nb[u] % bpw == 0) begin
                k = m_nb[u] / bpw - 1;
                m_we[u] = 1;
                m_a[u] = k;
                m_d[u] = (bpw == 1) ? {8'h00, mbuf[u][k]} : {mbuf[u][2*k+1], mbuf[u][2*k]};
              end
            end
          end
          if (finish) begin
            if (m_nb[u] % bpw != 0) begin
              m_we[u] = 1;
              m_a[u] = m_nb[u] / bpw;
              m_d[u] = {8'h00, mbuf[u][m_nb[u]-1]};
            end
            m_load[u] = 0;
            m_done[u] = 1;
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      model_step();
    end
  end

  task automatic cmp(input int u, input logic w, input logic [15:0] av, input logic [15:0] dv,
                     input logic [15:0] cv, input logic rv, input logic bv, input logic dnv,
                     input logic ov);
    string p;
    p = (u == 0) ? "dw8" : "dw16";
    chk({p, "_we"}, 32'(w), 32'(m_we[u]));
    chk({p, "_a"}, 32'(av), 32'(m_a[u]));
    chk({p, "_d"}, 32'(dv), 32'(m_d[u]));
    chk({p, "_count"}, 32'(cv), 32'(m_cnt[u]));
    chk({p, "_s_ready"}, 32'(rv), 32'(m_load[u]));
    chk({p, "_busy"}, 32'(bv), 32'(m_load[u]));
    chk({p, "_done"}, 32'(dnv), 32'(m_done[u]));
    chk({p, "_overflow"}, 32'(ov), 32'(m_ovf[u]));
  endtask

  // Per-cycle comparison against the model, plus a log of every write strobe
  initial begin
    forever begin
      @(negedge clock);
      cmp(0, we8, 16'(a8), 16'(d8), 16'(cnt8), rdy8, busy8, done8, ovf8);
      cmp(1, we16, 16'(a16), d16, 16'(cnt16), rdy16, busy16, done16, ovf16);
      if (we8) wr8.push_back({6'b0, a8, 8'h00, d8});
      if (we16) wr16.push_back({6'b0, a16, d16});
    end
  end

  task automatic cyc(input logic st, input logic fi, input logic v, input logic [7:0] b);
    @(negedge clock);
    start = st;
    finish = fi;
    s_valid = v;
    s_data = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int r;
    int dl;
    reset = 1'b0;
    start = 1'b0;
    finish = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    @(negedge clock);
    chk("rst_we", 32'(we8 | we16), 0);
    chk("rst_ready", 32'(rdy8 | rdy16), 0);
    chk("rst_a", 32'(a8 | a16), 0);
    chk("rst_d", 32'(d8) | 32'(d16), 0);
    chk("rst_count", 32'(cnt8 | cnt16), 0);
    chk("rst_flags", 32'({busy8, done8, ovf8, busy16, done16, ovf16}), 0);
    start = 1'b0; finish = 1'b0; s_valid = 1'b0;
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(1);
    chk("start_ready", 32'({rdy8, rdy16}), 32'h3);

    // Three back-to-back bytes, then finish
    wr8.delete(); wr16.delete();
    cyc(1'b0, 1'b0, 1'b1, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 8'h22);
    cyc(1'b0, 1'b0, 1'b1, 8'h33);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    idle(3);
    chk("t1_dw8_n", 32'(wr8.size()), 3);
    chk("t1_dw8_w0", q_at(wr8, 0), 32'h0000_0011);
    chk("t1_dw8_w1", q_at(wr8, 1), 32'h0001_0022);
    chk("t1_dw8_w2", q_at(wr8, 2), 32'h0002_0033);
    chk("t1_dw8_count", 32'(cnt8), 3);
    chk("t1_dw8_done", 32'({done8, ovf8}), 32'h2);

    // Gapped bytes; DW=16 completes one word and flushes the odd byte
    wr8.delete(); wr16.delete();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h34);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 8'h12);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 8'h78);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    idle(3);
    chk("t2_dw16_n", 32'(wr16.size()), 2);
    chk("t2_dw16_w0", q_at(wr16, 0), 32'h0000_1234);
    chk("t2_dw16_w1", q_at(wr16, 1), 32'h0001_0078);
    chk("t2_dw16_count", 32'(cnt16), 2);
    chk("t2_dw16_done", 32'(done16), 1);
    chk("t2_dw8_w2", q_at(wr8, 2), 32'h0002_0078);
    chk("t2_dw8_count", 32'(cnt8), 3);

    // Fill both memories and push two bytes past the end
    wr8.delete(); wr16.delete();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2050; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i));
    idle(3);
    chk("t3_dw8_n", 32'(wr8.size()), 1024);
    chk("t3_dw8_last", q_at(wr8, 1023), 32'h03FF_00FF);
    chk("t3_dw8_count", 32'(cnt8), 1024);
    chk("t3_dw8_ovf_ready", 32'({ovf8, rdy8}), 32'h3);
    chk("t3_dw16_n", 32'(wr16.size()), 1024);
    chk("t3_dw16_last", q_at(wr16, 1023), 32'h03FF_FFFE);
    chk("t3_dw16_count", 32'(cnt16), 1024);
    chk("t3_dw16_ovf_ready", 32'({ovf16, rdy16}), 32'h3);
    cyc(1'b0, 1'b1, 1'b1, 8'h99);
    idle(2);
    chk("t3_done", 32'({done8, done16, rdy8, rdy16}), 32'hC);
    chk("t3_count_final", 32'({cnt8, cnt16}), 32'({11'd1024, 11'd1024}));

    // Restart mid-load; byte offered alongside start is ignored
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i));
    idle(3);
    chk("t4_dw8_count5", 32'(cnt8), 5);
    chk("t4_dw16_count2", 32'(cnt16), 2);
    wr8.delete(); wr16.delete();
    cyc(1'b1, 1'b0, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, 1'b1, 8'hAA);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    idle(3);
    chk("t4_dw8_n", 32'(wr8.size()), 1);
    chk("t4_dw8_w0", q_at(wr8, 0), 32'h0000_00AA);
    chk("t4_dw16_n", 32'(wr16.size()), 1);
    chk("t4_dw16_w0", q_at(wr16, 0), 32'h0000_00AA);
    chk("t4_count", 32'({cnt8, cnt16}), 32'({11'd1, 11'd1}));
    chk("t4_ovf", 32'({ovf8, ovf16}), 0);

    // Async reset right after the accepting edge kills the strobe
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h5A);
    @(posedge clock);
    #1;
    chk("t5_we_before", 32'(we8), 1);
    reset = 1'b0;
    #1;
    chk("t5_we_after", 32'({we8, we16}), 0);
    chk("t5_outputs", 32'(a8) | 32'(d8) | 32'(cnt8) | 32'({rdy8, busy8, done8, ovf8}), 0);
    idle(2);
    start = 1'b0; s_valid = 1'b0;
    reset = 1'b1;
    idle(2);
    chk("t5_idle", 32'({rdy8, busy8, rdy16, busy16, we8, we16}), 0);

    // Randomized traffic, with occasional mid-cycle async resets
    for (int it = 0; it < 12000; it++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        @(negedge clock);
        dl = int'($urandom_range(1, 7));
        if (dl >= 5) dl++;
        #(dl);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
      end else begin
        cyc(r < 15, (r >= 15) && (r < 30), $urandom_range(0, 9) < 6, 8'($urandom));
      end
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
